// File: rtl/frame_rx_pin.sv
// Serial frame receiver: 2-flop line sync, mid-bit sampling, LSB-first deserialiser,
// even-parity and stop-bit checks, one-cycle result strobes.
module frame_rx_pin #(
    parameter int BAUD      = 10,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;

    state_t                 state;
    logic [1:0]             sync;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;

    assign rx_s = sync[1];

    // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= cnt + CNT_W'(1);
            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (bit_idx == IDX_LAST) state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        // Leaving at mid stop bit lets a back-to-back start edge be seen from IDLE.
                        if (cnt == BIT_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                data_out   <= shreg;
                                data_valid <= 1'b1;
                                parity_err <= (^shreg) ^ par_bit;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HI;
                            end
                        end
                    end
                    WAIT_HI: begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
